// File: rtl/dcache_wt_if.sv
// Shared system-bus connection of the write-through data cache.
// The cache is the master; the arbiter/memory side uses the slave modport.
interface dcache_wt_if;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] bus_addr;
  logic [31:0] bus_rdata;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ready;

  modport master (
    output bus_req, bus_addr, bus_wdata, bus_rd, bus_wr,
    input  bus_ack, bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_addr, bus_wdata, bus_rd, bus_wr,
    output bus_ack, bus_rdata, bus_ready
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Load hits are served combinationally; misses fill a whole line over the bus.
//
// state | meaning
// IDLE  | serve hits; detect a miss or a store
// FILL  | fetch the line word by word in ascending order
// WRITE | forward the store to the bus; patch the cached word on a hit
module dcache_wt #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rw_wait,
  dcache_wt_if.master bus
);
  localparam int TAG_LSB  = INDEX_BITS + WORD_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << WORD_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WORD_BITS-1:0]   cnt;
  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tag_mem [LINES];
  logic [31:0]            data_mem [LINES*WORDS];

  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  idx;
  logic [WORD_BITS-1:0]   wsel;
  logic                   hit;
  logic                   done;

  logic                   req;
  logic                   rd_strobe;
  logic                   wr_strobe;
  logic [31:0]            baddr;
  logic [31:0]            bwdata;
  logic                   unused_addr_lsb;

  assign tag  = addr[31:TAG_LSB];
  assign idx  = addr[TAG_LSB-1:WORD_BITS+2];
  assign wsel = addr[WORD_BITS+1:2];
  assign hit  = valid[idx] && (tag_mem[idx] == tag);
  assign done = (state != IDLE) && bus.bus_ack && bus.bus_ready;
  assign unused_addr_lsb = ^addr[1:0];

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
    end else begin
      state <= state_nxt;
      if (state == FILL && done) begin
        cnt <= cnt + 1'b1;
        if (&cnt) valid[idx] <= 1'b1;
      end else if (state == IDLE) begin
        cnt <= '0;
      end
    end
  end

  // Array contents need no reset; valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (state == FILL && done) begin
      data_mem[{idx, cnt}] <= bus.bus_rdata;
      if (&cnt) tag_mem[idx] <= tag;
    end
    if (state == WRITE && done && hit) data_mem[{idx, wsel}] <= wr_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_req) state_nxt = WRITE;
               else if (rd_req && !hit) state_nxt = FILL;
      FILL:    if (done && (&cnt)) state_nxt = IDLE;
      WRITE:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    rw_wait   = 1'b0;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    baddr     = '0;
    bwdata    = '0;
    case (state)
      IDLE: begin
        if (wr_req || (rd_req && !hit)) begin
          req     = 1'b1;
          rw_wait = 1'b1;
        end
      end
      FILL: begin
        req     = 1'b1;
        rw_wait = 1'b1;
        if (bus.bus_ack) begin
          rd_strobe = 1'b1;
          baddr     = {addr[31:WORD_BITS+2], cnt, 2'b00};
        end
      end
      WRITE: begin
        req     = 1'b1;
        rw_wait = !done;
        if (bus.bus_ack) begin
          wr_strobe = 1'b1;
          baddr     = {addr[31:2], 2'b00};
          bwdata    = wr_data;
        end
      end
      default: ;
    endcase
  end

  // Bus outputs are OR-combined with other masters, so idle values are zero.
  assign bus.bus_req   = req && Nrst;
  assign bus.bus_rd    = rd_strobe;
  assign bus.bus_wr    = wr_strobe;
  assign bus.bus_addr  = baddr;
  assign bus.bus_wdata = bwdata;

  assign rd_data = (rd_req && hit) ? data_mem[{idx, wsel}] : '0;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt against a behavioural bus memory.
// Memory word at 0x100 is 0xDEADBEEF; every other word reads as addr ^ 0xA5A50000.
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rw_wait;
  logic        ack_en;
  logic        ready_en;

  int total = 0;
  int bad   = 0;
  int leak  = 0;
  logic [31:0] rd_log [$];
  logic [31:0] wr_log [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  dcache_wt_if bus();
  assign bus.bus_ack   = ack_en;
  assign bus.bus_ready = ready_en;
  assign bus.bus_rdata = memf(bus.bus_addr);

  dcache_wt dut (
    .clk     (clk),
    .Nrst    (Nrst),
    .addr    (addr),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rw_wait (rw_wait),
    .bus     (bus)
  );

  always @(negedge clk) begin
    if (bus.bus_ack && bus.bus_ready && bus.bus_rd) rd_log.push_back(bus.bus_addr);
    if (bus.bus_ack && bus.bus_ready && bus.bus_wr) wr_log.push_back(bus.bus_addr);
    if (!bus.bus_ack && (bus.bus_rd || bus.bus_wr || bus.bus_addr != 0 || bus.bus_wdata != 0)) leak++;
    if (!bus.bus_rd && !bus.bus_wr && (bus.bus_addr != 0 || bus.bus_wdata != 0)) leak++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int waits);
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rw_wait) break;
      waits++;
    end
  endtask

  task automatic test_reset();
    Nrst = 1'b0; rd_req = 1'b1; wr_req = 1'b1; addr = 32'h100; wr_data = 32'h1;
    ack_en = 1'b1; ready_en = 1'b1;
    #12;
    total++; if (bus.bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b want=0", bus.bus_req); end
    total++; if ({bus.bus_rd, bus.bus_wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {bus.bus_rd, bus.bus_wr}); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    rd_req = 1'b0; wr_req = 1'b0;
    step();
    Nrst = 1'b1;
    @(negedge clk);
    total++; if ({rw_wait, bus.bus_req} !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%b want=00", {rw_wait, bus.bus_req}); end
    step();
  endtask

  task automatic test_cold_load();
    int w;
    rd_log.delete();
    rd_req = 1'b1; addr = 32'h100;
    wait_done(w);
    total++; if (w !== 5) begin bad++; $display("FAIL cold_wait_cycles got=%0d want=5", w); end
    total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL cold_rd_data got=%h want=deadbeef", rd_data); end
    step();
    total++; if (rd_log.size() !== 4) begin bad++; $display("FAIL cold_fill_count got=%0d want=4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_log[i] !== 32'h100 + 32'(4*i)) begin bad++; $display("FAIL cold_fill_addr%0d got=%h want=%h", i, rd_log[i], 32'h100 + 32'(4*i)); end
    end
  endtask

  task automatic test_hit();
    rd_log.delete();
    addr = 32'h108;
    @(negedge clk);
    total++; if (rw_wait !== 1'b0) begin bad++; $display("FAIL hit_wait got=%b want=0", rw_wait); end
    total++; if (rd_data !== 32'hA5A50108) begin bad++; $display("FAIL hit_rd_data got=%h want=a5a50108", rd_data); end
    total++; if (bus.bus_req !== 1'b0) begin bad++; $display("FAIL hit_bus_req got=%b want=0", bus.bus_req); end
    step();
    total++; if (rd_log.size() !== 0) begin bad++; $display("FAIL hit_bus_reads got=%0d want=0", rd_log.size()); end
    rd_req = 1'b0;
  endtask

  task automatic test_store_hit();
    wr_log.delete();
    ready_en = 1'b0; wr_req = 1'b1; addr = 32'h104; wr_data = 32'h12345678;
    @(negedge clk);
    total++; if ({rw_wait, bus.bus_req, bus.bus_wr} !== 3'b110) begin bad++; $display("FAIL st_detect got=%b want=110", {rw_wait, bus.bus_req, bus.bus_wr}); end
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({rw_wait, bus.bus_wr, bus.bus_rd} !== 3'b110) begin bad++; $display("FAIL st_stall%0d got=%b want=110", i, {rw_wait, bus.bus_wr, bus.bus_rd}); end
      total++; if (bus.bus_addr !== 32'h104 || bus.bus_wdata !== 32'h12345678) begin bad++; $display("FAIL st_bus%0d got=%h/%h want=00000104/12345678", i, bus.bus_addr, bus.bus_wdata); end
      step();
    end
    ready_en = 1'b1;
    @(negedge clk);
    total++; if (rw_wait !== 1'b0) begin bad++; $display("FAIL st_retire got=%b want=0", rw_wait); end
    step();
    wr_req = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    total++; if ({rw_wait, rd_data} !== {1'b0, 32'h12345678}) begin bad++; $display("FAIL st_reload got=%b/%h want=0/12345678", rw_wait, rd_data); end
    total++; if (wr_log.size() !== 1) begin bad++; $display("FAIL st_write_count got=%0d want=1", wr_log.size()); end
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_write_priority();
    rd_req = 1'b1; wr_req = 1'b1; addr = 32'h10C; wr_data = 32'h55AA55AA;
    @(negedge clk);
    total++; if (rw_wait !== 1'b1) begin bad++; $display("FAIL prio_wait got=%b want=1", rw_wait); end
    step();
    @(negedge clk);
    total++; if ({bus.bus_wr, bus.bus_rd, rw_wait} !== 3'b100) begin bad++; $display("FAIL prio_write got=%b want=100", {bus.bus_wr, bus.bus_rd, rw_wait}); end
    step();
    wr_req = 1'b0;
    @(negedge clk);
    total++; if ({rw_wait, rd_data} !== {1'b0, 32'h55AA55AA}) begin bad++; $display("FAIL prio_reload got=%b/%h want=0/55aa55aa", rw_wait, rd_data); end
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_store_miss();
    int w;
    wr_log.delete(); rd_log.delete();
    wr_req = 1'b1; addr = 32'h2000; wr_data = 32'hCAFEF00D;
    wait_done(w);
    total++; if (w !== 1) begin bad++; $display("FAIL sm_wait got=%0d want=1", w); end
    step();
    wr_req = 1'b0;
    total++; if (wr_log.size() !== 1 || wr_log[0] !== 32'h2000) begin bad++; $display("FAIL sm_bus_write got=%0d@%h want=1@00002000", wr_log.size(), wr_log[0]); end
    rd_req = 1'b1;
    wait_done(w);
    total++; if (w !== 5) begin bad++; $display("FAIL sm_load_miss got=%0d want=5", w); end
    total++; if (rd_data !== 32'hA5A52000) begin bad++; $display("FAIL sm_load_data got=%h want=a5a52000", rd_data); end
    step();
    rd_req = 1'b0;
    total++; if (rd_log.size() !== 4 || rd_log[0] !== 32'h2000) begin bad++; $display("FAIL sm_fill got=%0d@%h want=4@00002000", rd_log.size(), rd_log[0]); end
  endtask

  task automatic test_conflict();
    int w;
    rd_req = 1'b1; addr = 32'h500;
    wait_done(w);
    total++; if (w !== 5 || rd_data !== 32'hA5A50500) begin bad++; $display("FAIL evict_load got=%0d/%h want=5/a5a50500", w, rd_data); end
    step();
    addr = 32'h100;
    wait_done(w);
    total++; if (w !== 5 || rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL evict_reload got=%0d/%h want=5/deadbeef", w, rd_data); end
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_grant_withheld();
    int w;
    rd_log.delete();
    rd_req = 1'b1; addr = 32'h3000;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({bus.bus_rd, bus.bus_wr, bus.bus_addr, bus.bus_wdata} !== 66'h0) begin bad++; $display("FAIL nogrant_bus%0d got=%b%b/%h/%h want=all zero", i, bus.bus_rd, bus.bus_wr, bus.bus_addr, bus.bus_wdata); end
      total++; if ({rw_wait, bus.bus_req} !== 2'b11) begin bad++; $display("FAIL nogrant_hold%0d got=%b want=11", i, {rw_wait, bus.bus_req}); end
      step();
    end
    ack_en = 1'b1;
    wait_done(w);
    total++; if (w !== 3 || rd_data !== 32'hA5A53000) begin bad++; $display("FAIL nogrant_resume got=%0d/%h want=3/a5a53000", w, rd_data); end
    step();
    rd_req = 1'b0;
    total++; if (rd_log.size() !== 4) begin bad++; $display("FAIL nogrant_count got=%0d want=4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_log[i] !== 32'h3000 + 32'(4*i)) begin bad++; $display("FAIL nogrant_addr%0d got=%h want=%h", i, rd_log[i], 32'h3000 + 32'(4*i)); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int w;
    rd_req = 1'b1; addr = 32'h500;
    wait_done(w);
    step();
    addr = 32'h100;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    Nrst = 1'b0;
    #1;
    total++; if ({bus.bus_req, bus.bus_rd} !== 2'b00) begin bad++; $display("FAIL midrst_bus got=%b want=00", {bus.bus_req, bus.bus_rd}); end
    step();
    Nrst = 1'b1;
    @(negedge clk);
    total++; if ({rw_wait, bus.bus_req, rd_data} !== {2'b11, 32'h0}) begin bad++; $display("FAIL midrst_line_invalid got=%b%b/%h want=11/0", rw_wait, bus.bus_req, rd_data); end
    wait_done(w);
    total++; if (w !== 4 || rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_refill got=%0d/%h want=4/deadbeef", w, rd_data); end
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_bus_quiet();
    total++; if (leak !== 0) begin bad++; $display("FAIL bus_quiet got=%0d want=0", leak); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_hit();
    test_store_hit();
    test_write_priority();
    test_store_miss();
    test_conflict();
    test_grant_withheld();
    test_reset_mid_fill();
    test_bus_quiet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
